// File: rtl/ff_bist_pkg.sv
// Shared types and helpers for the ff_bist_seq flop self-test sequencer.
package ff_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Slice to LEN_W bits to get the "no failure seen" first_fail value.
  localparam logic [31:0] FIRST_FAIL_NONE = 32'hFFFF_FFFF;

  function automatic int clamp_len(input int req_len, input int pat_w);
    return (req_len > pat_w) ? pat_w : req_len;
  endfunction

endpackage

// File: rtl/ff_bist_cmp.sv
// Expected-bit register, q/qb mismatch detect, saturating error count and
// first-fail capture (capture built only with FF_BIST_FIRST_FAIL_EN).
module ff_bist_cmp
  import ff_bist_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             drive,
  input  logic             bit_in,
  input  logic             dut_q,
  input  logic             dut_qb,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [LEN_W-1:0] first_fail
);

  logic exp_bit;
  logic exp_valid;

  // The flop under test shows the bit driven last cycle, so compare against it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_bit   <= 1'b0;
      exp_valid <= 1'b0;
    end else begin
      exp_bit   <= bit_in;
      exp_valid <= drive;
    end
  end

  assign mismatch = exp_valid && ((dut_q != exp_bit) || (dut_qb == dut_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

`ifdef FF_BIST_FIRST_FAIL_EN
  logic [LEN_W-1:0] cmp_idx;

  // Indices never reach all ones because 2^LEN_W > PAT_W, so all ones means "none yet".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_idx    <= '0;
      first_fail <= FIRST_FAIL_NONE[LEN_W-1:0];
    end else if (clr) begin
      cmp_idx    <= '0;
      first_fail <= FIRST_FAIL_NONE[LEN_W-1:0];
    end else if (exp_valid) begin
      cmp_idx <= cmp_idx + LEN_W'(1);
      if (mismatch && (first_fail == FIRST_FAIL_NONE[LEN_W-1:0])) begin
        first_fail <= cmp_idx;
      end
    end
  end
`else
  assign first_fail = FIRST_FAIL_NONE[LEN_W-1:0];
`endif

endmodule

// File: rtl/ff_bist_seq.sv
// BIST sequencer for one converted flop: shifts a pattern onto d, LSB first,
// and checks q/qb. Optional first-fail capture: define FF_BIST_FIRST_FAIL_EN.
module ff_bist_seq
  import ff_bist_pkg::*;
#(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [LEN_W-1:0] first_fail
);

  state_t           state;
  logic [PAT_W-1:0] shift;
  logic [LEN_W-1:0] bits_left;
  logic [LEN_W-1:0] clen;
  logic             accept;
  logic             mismatch;

  assign clen   = LEN_W'(clamp_len(int'(len), PAT_W));
  assign accept = (state == IDLE) && start;

  // bits_left counts bits still to drive after the one currently on dut_d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bits_left <= '0;
      dut_d     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dut_d <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            pass <= 1'b0;
            if (clen == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state     <= RUN;
              dut_d     <= pattern[0];
              shift     <= pattern >> 1;
              bits_left <= clen - LEN_W'(1);
            end
          end
        end
        RUN: begin
          if (bits_left == '0) begin
            state <= DRAIN;
          end else begin
            dut_d     <= shift[0];
            shift     <= shift >> 1;
            bits_left <= bits_left - LEN_W'(1);
          end
        end
        DRAIN: begin
          // The final bit's compare lands this cycle, so fold it into pass.
          state <= DONE;
          done  <= 1'b1;
          pass  <= (err_cnt == '0) && !mismatch;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          dut_d <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          dut_d <= 1'b0;
        end
      endcase
    end
  end

  ff_bist_cmp #(
    .CNT_W(CNT_W),
    .LEN_W(LEN_W)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .drive     (state == RUN),
    .bit_in    (dut_d),
    .dut_q     (dut_q),
    .dut_qb    (dut_qb),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt),
    .first_fail(first_fail)
  );

endmodule

// File: tb/tb_ff_bist_seq.sv
// Self-checking bench for ff_bist_seq: directed plan cases plus random runs
// checked against a pattern-level reference model of the flop under test.
module tb_ff_bist_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] pattern = 16'h0000;
  logic [4:0]  len = 5'd0;
  logic        dut_d, dut_q, dut_qb, busy, done, pass;
  logic [7:0]  err_cnt;
  logic [4:0]  first_fail;
  logic        d2, busy2, done2, pass2;
  logic [2:0]  err2;
  logic [4:0]  ff2;
  logic        ff_q;
  int          fmode = 0;   // 0 ideal, 1 q stuck-0, 2 q stuck-1, 3 qb tied to q
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural flop under test with injectable faults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= 1'b0;
    else     ff_q <= dut_d;
  end
  assign dut_q  = (fmode == 1) ? 1'b0 : (fmode == 2) ? 1'b1 : ff_q;
  assign dut_qb = (fmode == 3) ? dut_q : ~dut_q;

  ff_bist_seq dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .dut_d(dut_d), .dut_q(dut_q), .dut_qb(dut_qb), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_fail(first_fail)
  );

  // Narrow-counter instance driven by a permanently stuck-at-0 flop.
  ff_bist_seq #(.PAT_W(16), .CNT_W(3), .LEN_W(5)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .pattern(pattern), .len(len),
    .dut_d(d2), .dut_q(1'b0), .dut_qb(1'b1), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2), .first_fail(ff2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the applied bits and decide which ones the faulty flop corrupts.
  function automatic void model(input logic [15:0] pat, input int n, input int mode,
                                output int errs, output int first);
    logic b, q, qb;
    errs  = 0;
    first = 31;
    for (int i = 0; i < n; i++) begin
      b  = pat[i];
      q  = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : b;
      qb = (mode == 3) ? q : ~q;
      if ((q != b) || (qb == q)) begin
        if (first == 31) first = i;
        errs++;
      end
    end
  endfunction

  task automatic run_case(input string tag, input logic [15:0] pat, input logic [4:0] l,
                          input int mode, input bit extra_start);
    int n, c, errs, first, exp_ff;
    n = (l > 5'd16) ? 16 : int'(l);
    model(pat, n, mode, errs, first);
`ifdef FF_BIST_FIRST_FAIL_EN
    exp_ff = first;
`else
    exp_ff = 31;
`endif
    @(negedge clk);
    pattern = pat;
    len     = l;
    fmode   = mode;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    c = 0;
    while (!done && c < 40) begin
      if (c < n) check({tag, "_d"}, {31'd0, dut_d}, {31'd0, pat[c]});
      start = extra_start && (c == 2);
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check({tag, "_lat"}, c, (n == 0) ? 0 : n + 1);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_err"}, {24'd0, err_cnt}, errs);
    check({tag, "_pass"}, {31'd0, pass}, (errs == 0) ? 32'd1 : 32'd0);
    check({tag, "_ff"}, {27'd0, first_fail}, exp_ff);
    if (n == 0) check({tag, "_d0"}, {31'd0, dut_d}, 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {30'd0, busy, dut_d}, 32'd0);
    @(negedge clk);
    check({tag, "_hold"}, {31'd0, pass}, (errs == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int c, seen;
    #12;
    check("rst_vals", {dut_d, busy, done, pass, err_cnt, first_fail}, {4'd0, 8'd0, 5'h1F});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_case("a5a5",   16'hA5A5, 5'd16, 0, 1'b0);
    run_case("stuck0", 16'h00F0, 5'd16, 1, 1'b0);
    run_case("qbeq",   16'h0003, 5'd2,  3, 1'b0);
    run_case("len0",   16'hFFFF, 5'd0,  0, 1'b0);
    run_case("clamp",  16'h1234, 5'd20, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_case("rand", 16'($urandom), 5'($urandom_range(0, 20)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Abort mid-run: everything returns to reset values at once and no done follows.
    @(negedge clk);
    pattern = 16'hFFFF; len = 5'd16; fmode = 1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("abort", {dut_d, busy, done, pass, err_cnt, first_fail}, {4'd0, 8'd0, 5'h1F});
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_nodone", seen, 0);

    // Saturating 3-bit counter: 16 failing bits must stop at 7.
    @(negedge clk);
    pattern = 16'hFFFF; len = 5'd16; fmode = 0; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    c = 0;
    @(negedge clk);
    while (!done2 && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("sat_lat", c, 17);
    check("sat_err", {29'd0, err2}, 32'd7);
    check("sat_pass", {31'd0, pass2}, 32'd0);
`ifdef FF_BIST_FIRST_FAIL_EN
    check("sat_ff", {27'd0, ff2}, 32'd0);
`else
    check("sat_ff", {27'd0, ff2}, 32'd31);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
